reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Multi-ported RISC-V integer register file; successor of the 2R1W regfile for dual-issue pipelines.
//  NUM_RD async read ports, NUM_WR sync write ports, x0 hardwired to zero, per-register busy scoreboard.
//  Storage has no per-entry reset and stays RAM-inferable; a clear FSM zeroes one entry per cycle.
//  Sits between ID (reads, alloc) and WB (writes).
// PARAMETERS
//  XLEN      32   data width (default from riscv_pkg)
//  NUM_REGS  32   architectural registers, power of 2, >=2 (default REG_SIZE)
//  NUM_RD    2    read ports, >=1
//  NUM_WR    2    write ports, >=1
//  AW        $clog2(NUM_REGS), localparam
// PORTS
//  clk        in   1            system clock, all state on posedge
//  rst_n      in   1            asynchronous, active-low reset
//  clear_req  in   1            pulse: start zeroing sweep (honoured in IDLE only)
//  ready      out  1            1 = IDLE, array valid; 0 = sweep in progress
//  raddr      in   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//  rdata      out  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  rbusy      out  NUM_RD       busy bit of raddr[i] (a producer is still in flight)
//  wen        in   NUM_WR       write enables
//  waddr      in   NUM_WR*AW    write addresses
//  wdata      in   NUM_WR*XLEN  write data
//  alloc_en   in   1            reserve alloc_rd as pending (issue of a producer)
//  alloc_rd   in   AW           register to mark busy
// BEHAVIOUR
//  Reset (async, rst_n=0): state=CLEAR, sweep ptr=1, all busy=0, ready=0, rbusy=0, rdata=0.
//  FSM states: CLEAR and IDLE.
//   - CLEAR: writes 0 to array[ptr] each cycle, ptr++. At ptr==NUM_REGS-1 (after that write), go to IDLE.
//   - After rst_n rises, ready=1 exactly NUM_REGS-1 cycles later.
//   - IDLE: clear_req=1 -> next cycle CLEAR with ptr=1 and all busy=0.
//  While ready=0: wen and alloc_en ignored; all rdata=0; all rbusy=0; clear_req ignored.
//  Reset asserted mid-sweep restarts the sweep from ptr=1.
//  Read (combinational, every port independent):
//   - raddr==0 -> rdata=0, rbusy=0.
//   - Otherwise array value, or the bypass value if RF_WR_BYPASS_EN is defined.
//  Write (posedge, IDLE only):
//   - Every wen[j] with waddr[j]!=0 writes array[waddr[j]]<=wdata[j].
//   - Same waddr on several ports: highest port index wins.
//  Scoreboard (posedge, IDLE only):
//   - wen[j] & waddr[j]!=0 clears busy[waddr[j]].
//   - alloc_en & alloc_rd!=0 sets busy[alloc_rd].
//   - Set beats clear on the same register in the same cycle (the new producer owns it).
//   - busy[0] is constant 0.
//   - rbusy[i]=busy[raddr[i]], registered state only, no bypass of same-cycle writes.
// CONFIGURATION
//  RF_WR_BYPASS_EN defined:
//   - Write-through forwarding: raddr[i]!=0 matching an enabled waddr[j] returns wdata[j] the same cycle.
//   - Highest matching j wins.
//   - rbusy is unaffected.
//  RF_WR_BYPASS_EN undefined:
//   - Reads return the pre-edge array value.
//   - The hazard unit must forward WB->ID itself.
// STRUCTURE
//  riscv_pkg: XLEN and REG_SIZE (existing); add rf_state_e enum {RF_CLEAR, RF_IDLE}.
//  Sub-module rf_scoreboard: busy vector with set/clear ports and NUM_RD lookup ports.
//  Array, write-priority resolution, bypass mux and FSM stay in reg_file_mp.
// TESTING
//  1. rst_n low 3 cycles then high -> ready=0 for 31 cycles, ready=1 on cycle 31, all rdata=0.
//  2. wen[0] x5=0xDEAD_BEEF and wen[1] x5=0x1234_5678 same edge -> next cycle raddr x5 returns 0x1234_5678.
//  3. wen[0] x7=0xA5A5_A5A5, raddr[0]=x7 same cycle
//     -> with RF_WR_BYPASS_EN: 0xA5A5_A5A5 that cycle.
//     -> without it: old value that cycle, new value next cycle.
//  4. wen x0=0xFFFF_FFFF, alloc_rd=0 -> rdata(x0)=0, rbusy(x0)=0.
//  5. alloc x9, then alloc x9 + wen x9 in the same cycle -> rbusy(x9)=1; a later lone wen x9 -> rbusy(x9)=0 next cycle.
//  6. Fill x1..x31 with nonzero values, clear_req, drop rst_n at sweep cycle 10
//     -> sweep restarts, ready after 31 cycles, every register reads 0, busy all 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core constants and types.
//   XLEN       integer register width
//   REG_SIZE   number of architectural integer registers
//   rf_state_e register-file sweep FSM states
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int REG_SIZE = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for in-flight producers.
//   clk, rst_n   clock, async active-low reset (all busy -> 0)
//   flush        zero the whole vector on the next edge (wins over everything)
//   clr_en/addr  NUM_WR clear ports (writeback retires a producer)
//   set_en/addr  one set port (issue allocates a producer); set beats clear
//   look_addr    NUM_RD lookup addresses, port i at [i*AW +: AW]
//   look_busy    registered busy bit per lookup port
// Entry 0 is held at 0 so x0 never reports a hazard.
module rf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [NUM_WR-1:0]                   clr_en,
  input  logic [NUM_WR*$clog2(NUM_REGS)-1:0]  clr_addr,
  input  logic                                set_en,
  input  logic [$clog2(NUM_REGS)-1:0]         set_addr,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]  look_addr,
  output logic [NUM_RD-1:0]                   look_busy
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_WR-1:0][AW-1:0] clr_a;
  logic [NUM_RD-1:0][AW-1:0] look_a;
  logic [NUM_REGS-1:0]       busy, busy_nxt;

  assign clr_a  = clr_addr;
  assign look_a = look_addr;

  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++)
      if (clr_en[j]) busy_nxt[clr_a[j]] = 1'b0;
    // set applied after clears: the newly issued producer owns the register
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    if (flush) busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_look
    assign look_busy[i] = busy[look_a[i]];
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported RISC-V integer register file.
//   clk, rst_n  clock, async active-low reset (restarts the zeroing sweep)
//   clear_req   pulse in IDLE: re-run the zeroing sweep, drop all busy bits
//   ready       1 = array valid (IDLE), 0 = sweep running
//   raddr/rdata NUM_RD combinational read ports (x0 reads 0)
//   rbusy       busy bit of each read address (registered state only)
//   wen/waddr/wdata NUM_WR write ports, highest port wins on collisions
//   alloc_en/alloc_rd mark a destination register busy at issue
// Optional: define RF_WR_BYPASS_EN for write-through forwarding of
// same-cycle writes to the read ports.
// The array has no reset so it stays RAM-inferable; the sweep zeroes one
// entry per cycle (x1..x(NUM_REGS-1)), x0 is never stored, only muxed to 0.
module reg_file_mp #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::REG_SIZE,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear_req,
  output logic                                ready,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]  raddr,
  output logic [NUM_RD*XLEN-1:0]              rdata,
  output logic [NUM_RD-1:0]                   rbusy,
  input  logic [NUM_WR-1:0]                   wen,
  input  logic [NUM_WR*$clog2(NUM_REGS)-1:0]  waddr,
  input  logic [NUM_WR*XLEN-1:0]              wdata,
  input  logic                                alloc_en,
  input  logic [$clog2(NUM_REGS)-1:0]         alloc_rd
);
  import riscv_pkg::*;

  localparam int AW = $clog2(NUM_REGS);

  rf_state_e                   state;
  logic [AW-1:0]               ptr;
  logic [XLEN-1:0]             mem [NUM_REGS];

  logic [NUM_RD-1:0][AW-1:0]   raddr_a;
  logic [NUM_RD-1:0][XLEN-1:0] rdata_a;
  logic [NUM_WR-1:0][AW-1:0]   waddr_a;
  logic [NUM_WR-1:0][XLEN-1:0] wdata_a;
  logic [NUM_WR-1:0]           wen_q;     // wen qualified by IDLE
  logic [NUM_RD-1:0]           sb_busy;

  assign raddr_a = raddr;
  assign waddr_a = waddr;
  assign wdata_a = wdata;
  assign rdata   = rdata_a;

  assign ready = (state == RF_IDLE);
  assign wen_q = ready ? wen : '0;

  // sweep FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_CLEAR;
      ptr   <= AW'(1);
    end else begin
      case (state)
        RF_CLEAR: begin
          ptr <= ptr + AW'(1);
          if (ptr == AW'(NUM_REGS - 1)) state <= RF_IDLE;
        end
        RF_IDLE: begin
          if (clear_req) begin
            state <= RF_CLEAR;
            ptr   <= AW'(1);
          end
        end
        default: state <= RF_CLEAR;
      endcase
    end
  end

  // array: sweep write or up to NUM_WR port writes; ascending loop makes
  // the highest-indexed port the last NBA, so it wins on equal addresses
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      mem[ptr] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (wen_q[j] && waddr_a[j] != '0) mem[waddr_a[j]] <= wdata_a[j];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [XLEN-1:0] rd;
    always_comb begin
      rd = '0;
      if (ready && raddr_a[i] != '0) begin
        rd = mem[raddr_a[i]];
`ifdef RF_WR_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++)
          if (wen_q[j] && waddr_a[j] == raddr_a[i]) rd = wdata_a[j];
`endif
      end
    end
    assign rdata_a[i] = rd;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (!ready || clear_req),
    .clr_en    (wen_q),
    .clr_addr  (waddr),
    .set_en    (ready && alloc_en),
    .set_addr  (alloc_rd),
    .look_addr (raddr),
    .look_busy (sb_busy)
  );

  assign rbusy = ready ? sb_busy : '0;
endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
  localparam int XLEN = 32, NUM_REGS = 32, NUM_RD = 2, NUM_WR = 2, AW = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clear_req, ready, alloc_en;
  logic [NUM_RD*AW-1:0]   raddr;
  logic [NUM_RD*XLEN-1:0] rdata;
  logic [NUM_RD-1:0]      rbusy;
  logic [NUM_WR-1:0]      wen;
  logic [NUM_WR*AW-1:0]   waddr;
  logic [NUM_WR*XLEN-1:0] wdata;
  logic [AW-1:0]          alloc_rd;

  int n_assert = 0, n_fail = 0;
  int              kind_q[$];
  int              port_q[$];
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd)
  );

  function automatic logic [XLEN-1:0] val(int r);
    return 32'hC300_0000 + 32'(r) * 32'h0001_0101;
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic rd(int p, int a); raddr[p*AW +: AW] = AW'(a); endtask
  task automatic wr(int p, int a, logic [XLEN-1:0] d);
    wen[p] = 1'b1; waddr[p*AW +: AW] = AW'(a); wdata[p*XLEN +: XLEN] = d;
  endtask
  task automatic idle_in(); wen = '0; alloc_en = 1'b0; clear_req = 1'b0; endtask

  // kind 0 = rdata, 1 = rbusy, 2 = ready
  task automatic expect_v(int k, int p, logic [XLEN-1:0] v);
    kind_q.push_back(k); port_q.push_back(p); exp_q.push_back(v);
  endtask

  task automatic check();
    int k, p;
    logic [XLEN-1:0] e, obs;
    string nm;
    #1;
    while (kind_q.size() > 0) begin
      k = kind_q.pop_front(); p = port_q.pop_front(); e = exp_q.pop_front();
      case (k)
        0:       begin obs = rdata[p*XLEN +: XLEN]; nm = "rdata"; end
        1:       begin obs = XLEN'(rbusy[p]);       nm = "rbusy"; end
        default: begin obs = XLEN'(ready);          nm = "ready"; end
      endcase
      n_assert++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s port%0d raddr=%0d observed=%h expected=%h", nm, p,
               raddr[p*AW +: AW], obs, e);
      end
    end
  endtask

  task automatic check_all_zero();
    for (int r = 0; r < NUM_REGS; r++) begin
      rd(0, r); rd(1, r);
      expect_v(0, 0, '0); expect_v(1, 1, '0);
      check();
    end
  endtask

  initial begin
    clear_req = 1'b0; alloc_en = 1'b0; alloc_rd = '0;
    wen = '0; waddr = '0; wdata = '0; raddr = '0;
    rd(0, 5); rd(1, 3);

    // 1. reset, then sweep length
    repeat (3) @(posedge clk);
    #1;
    expect_v(2, 0, '0); expect_v(0, 0, '0); expect_v(0, 1, '0);
    expect_v(1, 0, '0); expect_v(1, 1, '0);
    check();
    rst_n = 1'b1;
    repeat (30) tick();
    expect_v(2, 0, '0); check();
    tick();
    expect_v(2, 0, 1); check();
    check_all_zero();

    // 2. both ports write x5, highest port wins
    wr(0, 5, 32'hDEAD_BEEF); wr(1, 5, 32'h1234_5678);
    tick(); idle_in();
    rd(0, 5); rd(1, 5);
    expect_v(0, 0, 32'h1234_5678); expect_v(0, 1, 32'h1234_5678);
    check();

    // 3. same-cycle read of a register being written
    wr(0, 7, 32'hA5A5_A5A5); rd(0, 7);
`ifdef RF_WR_BYPASS_EN
    expect_v(0, 0, 32'hA5A5_A5A5);
`else
    expect_v(0, 0, 32'h0);
`endif
    check();
    tick(); idle_in();
    expect_v(0, 0, 32'hA5A5_A5A5); check();

    // 4. x0 is never written nor busy
    wr(0, 0, 32'hFFFF_FFFF); alloc_en = 1'b1; alloc_rd = '0; rd(0, 0);
    expect_v(0, 0, '0); expect_v(1, 0, '0); check();
    tick(); idle_in();
    expect_v(0, 0, '0); expect_v(1, 0, '0); check();

    // 5. busy scoreboard: set beats clear, lone write clears, no bypass
    alloc_en = 1'b1; alloc_rd = AW'(9);
    tick(); idle_in();
    rd(1, 9);
    expect_v(1, 1, 1); check();
    alloc_en = 1'b1; alloc_rd = AW'(9); wr(0, 9, 32'h0000_0055);
    tick(); idle_in();
    expect_v(1, 1, 1); expect_v(0, 1, 32'h0000_0055); check();
    wr(1, 9, 32'h0000_0066);
    expect_v(1, 1, 1); check();
    tick(); idle_in();
    expect_v(1, 1, 0); expect_v(0, 1, 32'h0000_0066); check();

    // 6. fill, clear, reset mid-sweep, writes/allocs ignored while sweeping
    for (int r = 1; r < NUM_REGS; r += 2) begin
      wr(0, r, val(r));
      if (r + 1 < NUM_REGS) wr(1, r + 1, val(r + 1));
      tick(); idle_in();
    end
    alloc_en = 1'b1; alloc_rd = AW'(12);
    tick(); idle_in();
    rd(0, 31); rd(1, 12);
    expect_v(0, 0, val(31)); expect_v(1, 1, 1); check();
    rd(0, 20);
    expect_v(0, 0, val(20)); check();
    clear_req = 1'b1;
    tick(); idle_in();
    expect_v(2, 0, '0); expect_v(0, 0, '0); expect_v(1, 1, '0); check();
    repeat (9) tick();
    rst_n = 1'b0;
    expect_v(2, 0, '0); check();
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    wr(0, 2, 32'h0000_0BAD); alloc_en = 1'b1; alloc_rd = AW'(25);
    expect_v(0, 0, '0); check();
    tick(); idle_in();
    repeat (24) tick();
    expect_v(2, 0, '0); check();
    tick();
    expect_v(2, 0, 1); check();
    check_all_zero();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
